lsu_subword: RTL and testbench
==============================

# lsu_subword

Load/store unit between the RV32I datapath and the 20-bit byte-addressed data memory. It converts core load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into whole-word memory accesses: it sign- or zero-extends load data and performs read-modify-write for byte and halfword stores, because the memory only writes 4 bytes at a time. A ready/resp handshake stalls the core for the 1–2 extra cycles that sub-word stores need.

## Interface
- `ADDR_W`, default 20: memory address width; core address bits above it are ignored.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  1  core request; sampled only while `ready`=1.
- `we`  in  1  1 = store, 0 = load.
- `funct3`  in  3  RV32I width/sign code: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data; low byte or half is used for SB/SH.
- `ready`  out  1  unit idle, can accept `req`.
- `resp_valid`  out  1  one-cycle completion pulse.
- `rdata`  out  32  extended load result; valid with `resp_valid`, and held until the next response.
- `fault`  out  1  valid with `resp_valid`; marks an illegal funct3 or a trapped misalignment.
- `mem_addr`  out  ADDR_W  to memory `addr`.
- `mem_din`  out  32  to memory `din`.
- `mem_we`  out  1  to memory `MemWrite`.
- `mem_dout`  in  32  from memory `dout`: combinational read of bytes addr..addr+3, little-endian.

## Operation
- States: IDLE, LOAD, RMW_RD, RMW_WR, RESP.
- IDLE:
  - `ready`=1.
  - `mem_addr` = `addr[ADDR_W-1:0]` combinationally.
  - On `req`, latch `addr`, `wdata`, `funct3` and `we`.
- Transitions out of IDLE on `req`:
  - Load → LOAD.
  - SW → drive `mem_we`=1 and `mem_din`=`wdata` in the same cycle, then → RESP.
  - SB/SH → RMW_RD.
  - Illegal funct3 (3, 6, 7, or any store code ≥3) → RESP with `fault`=1 and no memory access.
- LOAD: `mem_addr`=latched address. Capture `mem_dout` and extend it into `rdata`:
  - LB: sign-extend bits [7:0].
  - LBU: zero-extend bits [7:0].
  - LH: sign-extend bits [15:0].
  - LHU: zero-extend bits [15:0].
  - LW: full word.
  - Then → RESP.
- RMW_RD: capture `mem_dout` into a merge register, then → RMW_WR.
- RMW_WR:
  - `mem_we`=1.
  - `mem_din` = merge register with byte 0 (SB) or bytes 1:0 (SH) replaced from latched `wdata`.
  - Then → RESP.
- RESP:
  - `resp_valid`=1, `ready`=0, then → IDLE.
  - `rdata` changes only on loads; stores and faults leave it unchanged.
- `mem_we` is 0 in every state other than IDLE-with-SW and RMW_WR. Outside IDLE, `mem_addr` always equals the latched address.
- Address arithmetic is 20 bits. Bytes at addr+1..+3 wrap modulo 2^20 inside the memory; the unit does no wrap handling.

## Timing
- Request to `resp_valid` (counting from the edge that accepts the request):
  - Loads: 2 cycles.
  - SW: 1 cycle.
  - SB/SH: 3 cycles.
  - Fault: 1 cycle.
- `ready` deasserts the cycle after acceptance. Back-to-back requests are possible every (latency + 1) cycles.
- Reset values: state IDLE, `ready`=1, `resp_valid`=0, `rdata`=0, `fault`=0, `mem_we`=0. All latches are cleared to 0.
- Reset asserted mid-operation aborts immediately:
  - `mem_we` drops asynchronously and no partial write is issued.
  - No response is produced for the aborted request.
- `req` asserted while `ready`=0 is ignored. The core must hold `req` until it sees `ready`.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - LH/LHU/SH with `addr[0]`=1, or LW/SW with `addr[1:0]`≠0, go IDLE→RESP with `fault`=1, 1-cycle latency, and no memory access or write.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - Misaligned accesses proceed normally, since the memory supports unaligned word access.
  - `fault` is raised only for an illegal funct3.

## Test plan
- Memory word at 12 = 0xFFFFFFB7. LB, LBU, and LHU at 12 → `rdata` 0xFFFFFFB7, 0x000000B7, and 0x0000FFB7 respectively, each with `resp_valid` 2 cycles after acceptance.
- Word at 8 = 0x0000002C. SB with `wdata`=0x123456AA at 8, then LW 8 → 0x000000AA. `mem_we` is high exactly one cycle, in RMW_WR.
- SW 0xDEADBEEF at 40, then LH at 42 → 0xFFFFDEAD. SW `resp_valid` arrives 1 cycle after acceptance.
- Word at 12 = 0xFFFFFFB7, byte 16 = 0. LW at 13:
  - Macro defined → `fault`=1, `mem_we` never asserted.
  - Macro undefined → `rdata`=0x00FFFFFF, `fault`=0.
- funct3=3 load → `fault`=1 after 1 cycle, `rdata` unchanged, no memory access.
- Assert `reset_n`=0 during RMW_WR of an SH → `mem_we` falls immediately, target word unchanged, `ready`=1 after release, `resp_valid` never pulses.

Source files
------------

// File: rtl/lsu_subword.sv
// Sub-word load/store unit: turns RV32I byte/half/word accesses into whole-word memory
// accesses, with extension on loads and read-modify-write on SB/SH. Option: LSU_MISALIGN_TRAP_EN.
module lsu_subword #(
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              resp_valid,
  output logic [31:0]       rdata,
  output logic              fault,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              mem_we,
  input  logic [31:0]       mem_dout
);

  // state  | meaning
  // IDLE   | ready, accept request; SW writes here directly
  // LOAD   | capture and extend mem_dout into rdata
  // RMW_RD | capture the target word for a sub-word store
  // RMW_WR | write the merged word back
  // RESP   | one-cycle completion pulse
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RMW_RD, S_RMW_WR, S_RESP} state_t;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  addr_q;
  logic [15:0]        wdata_q;
  logic [2:0]         funct3_q;
  logic [31:0]        merge_q;
  logic               illegal;
  logic               misalign;
  logic               bad;
  logic               unused_addr;

  assign unused_addr = ^addr[31:ADDR_W];

  always_comb begin
    illegal = we ? (funct3 > 3'd2)
                 : !(funct3 == 3'd0 || funct3 == 3'd1 || funct3 == 3'd2 ||
                     funct3 == 3'd4 || funct3 == 3'd5);
`ifdef LSU_MISALIGN_TRAP_EN
    misalign = ((funct3 == 3'd1 || funct3 == 3'd5) && addr[0]) ||
               (funct3 == 3'd2 && addr[1:0] != 2'b00);
`else
    misalign = 1'b0;
`endif
    bad = illegal || misalign;
  end

  function automatic logic [31:0] extend(input logic [31:0] d, input logic [2:0] f3);
    case (f3)
      3'd0:    extend = {{24{d[7]}}, d[7:0]};
      3'd1:    extend = {{16{d[15]}}, d[15:0]};
      3'd4:    extend = {24'd0, d[7:0]};
      3'd5:    extend = {16'd0, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_din   = (funct3_q == 3'd0) ? {merge_q[31:8], wdata_q[7:0]}
                                   : {merge_q[31:16], wdata_q[15:0]};
    case (state)
      S_IDLE: begin
        mem_addr = addr[ADDR_W-1:0];
        mem_din  = wdata;
        if (req) begin
          if (bad)                state_nxt = S_RESP;
          else if (!we)           state_nxt = S_LOAD;
          else if (funct3 == 3'd2) begin
            mem_we    = 1'b1;
            state_nxt = S_RESP;
          end else                state_nxt = S_RMW_RD;
        end
      end
      S_LOAD:   state_nxt = S_RESP;
      S_RMW_RD: state_nxt = S_RMW_WR;
      S_RMW_WR: begin
        mem_we    = 1'b1;
        state_nxt = S_RESP;
      end
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    // reset must kill a write even while the core holds an SW request in IDLE
    mem_we = mem_we && reset_n;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      merge_q  <= '0;
      rdata    <= '0;
      fault    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (req) begin
          addr_q   <= addr[ADDR_W-1:0];
          wdata_q  <= wdata[15:0];
          funct3_q <= funct3;
          fault    <= bad;
        end
        S_LOAD:   rdata   <= extend(mem_dout, funct3_q);
        S_RMW_RD: merge_q <= mem_dout;
        default: ;
      endcase
    end
  end

  assign ready      = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);

endmodule

// File: tb/tb_lsu_subword.sv
// Randomised and directed bench for lsu_subword against a byte-array reference memory.
// Follows LSU_MISALIGN_TRAP_EN the same way the design does.
module tb_lsu_subword;

  localparam int MSZ = 1 << 20;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        ready, resp_valid, fault, mem_we;
  logic [31:0] rdata, mem_din, mem_dout;
  logic [19:0] mem_addr;

  logic [7:0]  mem [MSZ];
  logic [7:0]  ref_mem [MSZ];
  int          we_total = 0;
  int          resp_cnt = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_rdata = '0;

  lsu_subword #(.ADDR_W(20)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .ready(ready), .resp_valid(resp_valid),
    .rdata(rdata), .fault(fault), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_we(mem_we), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  assign mem_dout = {mem[mem_addr + 20'd3], mem[mem_addr + 20'd2],
                     mem[mem_addr + 20'd1], mem[mem_addr]};

  always @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) mem[mem_addr + 20'(i)] <= mem_din[8*i +: 8];
      we_total <= we_total + 1;
    end
    if (resp_valid) resp_cnt <= resp_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [19:0] a);
    return {ref_mem[a + 20'd3], ref_mem[a + 20'd2], ref_mem[a + 20'd1], ref_mem[a]};
  endfunction

  function automatic logic [31:0] mem_word(input logic [19:0] a);
    return {mem[a + 20'd3], mem[a + 20'd2], mem[a + 20'd1], mem[a]};
  endfunction

  task automatic set_word(input logic [19:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      mem[a + 20'(i)]     = w[8*i +: 8];
      ref_mem[a + 20'(i)] = w[8*i +: 8];
    end
  endtask

  task automatic do_op(input string tag, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    int          n, w0, lat, nwr;
    bit          bad;
    logic [19:0] la;
    logic [31:0] word, v;
    la  = a[19:0];
    bad = w ? (f3 > 3'd2) : !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) bad = 1'b1;
    if (f3 == 3'd2 && a[1:0] != 2'b00) bad = 1'b1;
`endif
    if (bad) begin
      lat = 1; nwr = 0;
    end else if (!w) begin
      lat = 2; nwr = 0;
      word = ref_word(la);
      case (f3)
        3'd0: begin v = word & 32'hFF;   if (v[7])  v = v | 32'hFFFFFF00; end
        3'd1: begin v = word & 32'hFFFF; if (v[15]) v = v | 32'hFFFF0000; end
        3'd4: v = word & 32'hFF;
        3'd5: v = word & 32'hFFFF;
        default: v = word;
      endcase
      exp_rdata = v;
    end else begin
      nwr = 1;
      lat = (f3 == 3'd2) ? 1 : 3;
      for (int i = 0; i < (1 << f3); i++) ref_mem[la + 20'(i)] = wd[8*i +: 8];
    end

    n = 0;
    while (!ready && n < 20) begin @(negedge clk); n++; end
    check({tag, "_ready"}, {31'd0, ready}, 32'd1);

    req = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd;
    w0 = we_total;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    n = 1;
    while (!resp_valid && n < 10) begin @(negedge clk); n++; end
    check({tag, "_lat"},    32'(n), 32'(lat));
    check({tag, "_busy"},   {31'd0, ready}, 32'd0);
    check({tag, "_rdata"},  rdata, exp_rdata);
    check({tag, "_fault"},  {31'd0, fault}, {31'd0, bad});
    check({tag, "_writes"}, 32'(we_total - w0), 32'(nwr));
    if (w && !bad) check({tag, "_memword"}, mem_word(la), ref_word(la));
  endtask

  initial begin
    int          rc0;
    logic [2:0]  f3;
    logic [19:0] low;
    for (int i = 0; i < MSZ; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_resp",  {31'd0, resp_valid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_we",    {31'd0, mem_we}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    set_word(20'd12, 32'hFFFFFFB7);
    set_word(20'd16, 32'h00000000);
    set_word(20'd8,  32'h0000002C);
    do_op("lb12",  1'b0, 3'd0, 32'd12, 32'd0);
    check("lb12_val", rdata, 32'hFFFFFFB7);
    do_op("lbu12", 1'b0, 3'd4, 32'd12, 32'd0);
    check("lbu12_val", rdata, 32'h000000B7);
    do_op("lhu12", 1'b0, 3'd5, 32'd12, 32'd0);
    check("lhu12_val", rdata, 32'h0000FFB7);
    do_op("sb8",   1'b1, 3'd0, 32'd8, 32'h123456AA);
    do_op("lw8",   1'b0, 3'd2, 32'd8, 32'd0);
    check("lw8_val", rdata, 32'h000000AA);
    do_op("sw40",  1'b1, 3'd2, 32'd40, 32'hDEADBEEF);
    do_op("lh42",  1'b0, 3'd1, 32'd42, 32'd0);
    check("lh42_val", rdata, 32'hFFFFDEAD);
    do_op("lw13",  1'b0, 3'd2, 32'd13, 32'd0);
    do_op("ld_f3", 1'b0, 3'd3, 32'd12, 32'd0);
    do_op("sh_wrap", 1'b1, 3'd1, 32'hABCFFFFF, 32'h0000BEEF);
    do_op("lw_wrap", 1'b0, 3'd2, 32'h000FFFFE, 32'd0);

    // abort an SH in its write cycle
    set_word(20'd100, 32'h11223344);
    @(negedge clk);
    req = 1'b1; we = 1'b1; funct3 = 3'd1; addr = 32'd100; wdata = 32'hAAAA5555;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    #2;
    check("abort_we_pre", {31'd0, mem_we}, 32'd1);
    rc0 = resp_cnt;
    reset_n = 1'b0;
    #1;
    check("abort_we", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_ready", {31'd0, ready}, 32'd1);
    check("abort_resp",  32'(resp_cnt - rc0), 32'd0);
    check("abort_word",  mem_word(20'd100), 32'h11223344);
    exp_rdata = '0;
    do_op("post_abort", 1'b0, 3'd2, 32'd100, 32'd0);

    for (int i = 0; i < 128; i++) begin
      mem[i] = 8'($urandom); ref_mem[i] = mem[i];
      mem[MSZ - 1 - i] = 8'($urandom); ref_mem[MSZ - 1 - i] = mem[MSZ - 1 - i];
    end
    for (int k = 0; k < 150; k++) begin
      case ($urandom_range(0, 9))
        0:       f3 = 3'($urandom_range(0, 7));
        1, 2:    f3 = 3'd0;
        3, 4:    f3 = 3'd1;
        5, 6:    f3 = 3'd2;
        7:       f3 = 3'd4;
        default: f3 = 3'd5;
      endcase
      low = ($urandom_range(0, 3) == 0) ? 20'hFFFFC + 20'($urandom_range(0, 3))
                                        : 20'($urandom_range(0, 63));
      do_op("rnd", 1'($urandom_range(0, 1)), f3, {12'($urandom), low}, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
